// File: rtl/fsm_tx_ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fsm_tx_ps2_pkg
// Brief    : Shared state encoding and frame helpers for the PS/2 host TX FSM.
// Revision : 1.0 - initial release
// ============================================================================
package fsm_tx_ps2_pkg;

    localparam int PS2_FRAME_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RTS   = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4,
        ST_DONE  = 3'd5
    } tx_state_t;

    // Data byte with odd parity appended above the MSB, so shifting right sends LSB first.
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
        return {~^data, data};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_tx_ps2.sv
`default_nettype none
// ============================================================================
// Module   : fsm_tx_ps2
// Brief    : PS/2 host-to-device transmit controller (inhibit, start, 8 data,
//            odd parity, stop/ACK) with open-drain style line drivers.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_tx_ps2
    import fsm_tx_ps2_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    inout  wire        ps2_d,
    inout  wire        ps2_c,
    input  logic       ps2_write,
    input  logic [7:0] datain,
    input  logic       fall_edge,
    input  logic       ready_seg,
    input  logic       trama_terminada,
    output logic       cont_enasec,
    output logic       cont_enabits,
    output logic       ps2_tx_idle,
    output logic       ps2_tx_done
);

    tx_state_t                 r_state;
    tx_state_t                 w_next;
    logic [PS2_FRAME_BITS-1:0] r_shift;
    logic                      w_drive_c;
    logic                      w_drive_d;
    logic                      w_d_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Shifting only on non-terminal edges leaves parity on bit 0 for the last data slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
        end else if (r_state == ST_IDLE && ps2_write) begin
            r_shift <= ps2_frame(datain);
        end else if (r_state == ST_DATA && fall_edge && !trama_terminada) begin
            r_shift <= r_shift >> 1;
        end
    end

    always_comb begin
        w_next       = r_state;
        cont_enasec  = 1'b0;
        cont_enabits = 1'b0;
        ps2_tx_idle  = 1'b0;
        ps2_tx_done  = 1'b0;
        w_drive_c    = 1'b0;
        w_drive_d    = 1'b0;
        w_d_val      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ps2_tx_idle = 1'b1;
                if (ps2_write) w_next = ST_RTS;
            end
            ST_RTS: begin
                w_drive_c   = 1'b1;
                cont_enasec = 1'b1;
                if (ready_seg) w_next = ST_START;
            end
            ST_START: begin
                w_drive_d    = 1'b1;
                cont_enabits = 1'b1;
                if (fall_edge) w_next = ST_DATA;
            end
            ST_DATA: begin
                w_drive_d    = 1'b1;
                w_d_val      = r_shift[0];
                cont_enabits = 1'b1;
                if (fall_edge && trama_terminada) w_next = ST_STOP;
            end
            ST_STOP: begin
                if (fall_edge) w_next = ST_DONE;
            end
            ST_DONE: begin
                ps2_tx_done = 1'b1;
                w_next      = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign ps2_c = w_drive_c ? 1'b0    : 1'bz;
    assign ps2_d = w_drive_d ? w_d_val : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_fsm_tx_ps2.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_tx_ps2
// Brief    : Directed self-checking bench for fsm_tx_ps2 (lines pulled up).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_tx_ps2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_write = 1'b0;
    logic [7:0] datain = 8'h00;
    logic       fall_edge = 1'b0;
    logic       ready_seg = 1'b0;
    logic       trama_terminada = 1'b0;
    logic       cont_enasec;
    logic       cont_enabits;
    logic       ps2_tx_idle;
    logic       ps2_tx_done;
    wire        ps2_d_w;
    wire        ps2_c_w;

    pullup u_pu_d (ps2_d_w);
    pullup u_pu_c (ps2_c_w);

    int n_vec = 0;
    int n_err = 0;

    // {idle, done, enasec, enabits, clk line, data line}; a released line reads 1.
    localparam logic [5:0] E_IDLE  = 6'b100011;
    localparam logic [5:0] E_RTS   = 6'b001001;
    localparam logic [5:0] E_START = 6'b000110;
    localparam logic [5:0] E_STOP  = 6'b000011;
    localparam logic [5:0] E_DONE  = 6'b010011;

    wire [5:0] w_obs = {ps2_tx_idle, ps2_tx_done, cont_enasec, cont_enabits, ps2_c_w, ps2_d_w};

    fsm_tx_ps2 dut (
        .clk             (clk),
        .rst             (rst),
        .ps2_d           (ps2_d_w),
        .ps2_c           (ps2_c_w),
        .ps2_write       (ps2_write),
        .datain          (datain),
        .fall_edge       (fall_edge),
        .ready_seg       (ready_seg),
        .trama_terminada (trama_terminada),
        .cont_enasec     (cont_enasec),
        .cont_enabits    (cont_enabits),
        .ps2_tx_idle     (ps2_tx_idle),
        .ps2_tx_done     (ps2_tx_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        fall_edge = 1'b1;
        ready_seg = 1'b1;
        ps2_write = 1'b1;
        tick();
        tick();
        n_vec++;
        if (w_obs !== E_IDLE) begin
            n_err++;
            $display("FAIL reset_held: got %b expected %b", w_obs, E_IDLE);
        end
        fall_edge = 1'b0;
        ready_seg = 1'b0;
        ps2_write = 1'b0;
        rst       = 1'b0;
        tick();
        n_vec++;
        if (w_obs !== E_IDLE) begin
            n_err++;
            $display("FAIL reset_release: got %b expected %b", w_obs, E_IDLE);
        end
    endtask

    // Full frame; exp_bits holds {parity, D7..D0}. wiggle disturbs inputs mid-frame.
    task automatic test_frame(input logic [7:0] data, input logic [8:0] exp_bits, input bit wiggle);
        logic [5:0] exp;
        datain    = data;
        ps2_write = 1'b1;
        tick();
        ps2_write = 1'b0;
        n_vec++;
        if (w_obs !== E_RTS) begin
            n_err++;
            $display("FAIL frame_rts_entry: got %b expected %b", w_obs, E_RTS);
        end
        for (int i = 0; i < 3; i++) begin
            fall_edge       = 1'b1;
            trama_terminada = (i == 1);
            tick();
            fall_edge       = 1'b0;
            trama_terminada = 1'b0;
            n_vec++;
            if (w_obs !== E_RTS) begin
                n_err++;
                $display("FAIL frame_rts_fall_edge%0d: got %b expected %b", i, w_obs, E_RTS);
            end
        end
        ready_seg = 1'b1;
        tick();
        ready_seg = 1'b0;
        tick();
        n_vec++;
        if (w_obs !== E_START) begin
            n_err++;
            $display("FAIL frame_start: got %b expected %b", w_obs, E_START);
        end
        for (int k = 1; k <= 11; k++) begin
            fall_edge       = 1'b1;
            trama_terminada = (k == 10);
            tick();
            fall_edge       = 1'b0;
            trama_terminada = 1'b0;
            if (k <= 9)       exp = {5'b00011, exp_bits[k-1]};
            else if (k == 10) exp = E_STOP;
            else              exp = E_DONE;
            n_vec++;
            if (w_obs !== exp) begin
                n_err++;
                $display("FAIL frame_%02h_edge%0d: got %b expected %b", data, k, w_obs, exp);
            end
            if (k <= 10) begin
                if (wiggle && k >= 2 && k <= 6) begin
                    ps2_write       = 1'b1;
                    datain          = ~data;
                    trama_terminada = 1'b1;
                end
                tick();
                ps2_write       = 1'b0;
                trama_terminada = 1'b0;
                n_vec++;
                if (w_obs !== exp) begin
                    n_err++;
                    $display("FAIL frame_%02h_hold%0d: got %b expected %b", data, k, w_obs, exp);
                end
            end
        end
        tick();
        n_vec++;
        if (w_obs !== E_IDLE) begin
            n_err++;
            $display("FAIL frame_%02h_back_idle: got %b expected %b", data, w_obs, E_IDLE);
        end
        tick();
        n_vec++;
        if (w_obs !== E_IDLE) begin
            n_err++;
            $display("FAIL frame_%02h_stay_idle: got %b expected %b", data, w_obs, E_IDLE);
        end
    endtask

    task automatic test_back_to_back();
        datain    = 8'h3C;
        ps2_write = 1'b1;
        tick();
        ready_seg = 1'b1;
        tick();
        ready_seg = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            fall_edge       = 1'b1;
            trama_terminada = (k == 10);
            tick();
        end
        fall_edge       = 1'b0;
        trama_terminada = 1'b0;
        n_vec++;
        if (w_obs !== E_DONE) begin
            n_err++;
            $display("FAIL b2b_done: got %b expected %b", w_obs, E_DONE);
        end
        tick();
        n_vec++;
        if (w_obs !== E_IDLE) begin
            n_err++;
            $display("FAIL b2b_idle: got %b expected %b", w_obs, E_IDLE);
        end
        tick();
        ps2_write = 1'b0;
        n_vec++;
        if (w_obs !== E_RTS) begin
            n_err++;
            $display("FAIL b2b_restart: got %b expected %b", w_obs, E_RTS);
        end
    endtask

    task automatic test_reset_mid_data();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        datain    = 8'hF4;
        ps2_write = 1'b1;
        tick();
        ps2_write = 1'b0;
        ready_seg = 1'b1;
        tick();
        ready_seg = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            fall_edge = 1'b1;
            tick();
            fall_edge = 1'b0;
        end
        n_vec++;
        if (w_obs !== 6'b000111) begin
            n_err++;
            $display("FAIL mid_data_bit2: got %b expected %b", w_obs, 6'b000111);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (w_obs !== E_IDLE) begin
            n_err++;
            $display("FAIL async_reset_immediate: got %b expected %b", w_obs, E_IDLE);
        end
        tick();
        rst = 1'b0;
        tick();
        n_vec++;
        if (w_obs !== E_IDLE) begin
            n_err++;
            $display("FAIL after_async_reset: got %b expected %b", w_obs, E_IDLE);
        end
    endtask

    initial begin
        test_reset();
        test_frame(8'hF4, 9'b0_1111_0100, 1'b0);
        test_frame(8'h00, 9'b1_0000_0000, 1'b0);
        test_frame(8'hA5, 9'b1_1010_0101, 1'b1);
        test_back_to_back();
        test_reset_mid_data();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
